output_drain_packer: RTL and testbench

- Sits directly downstream of the systolic array and global controller; it is the consumer enabled by ctrl_drain_en.
- Accepts one row of NUM_COL accumulator results per handshake.
- Requantizes each result: arithmetic right shift with round-half-up, then saturate to signed 8-bit.
- Packs four int8 lanes per 32-bit beat onto an AXI-Stream master toward the output DMA, then pulses drain_done back to the controller.

---
 rtl/output_drain_packer_if.sv | 27 ++
 rtl/output_drain_packer.sv | 77 +++++++
 tb/tb_output_drain_packer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/output_drain_packer_if.sv
// output_drain_packer_if: controller, accumulator-row and AXI-Stream signals of the drain packer.
interface output_drain_packer_if #(
    parameter int NUM_COL   = 8,
    parameter int ACC_W     = 32,
    parameter int ROW_CNT_W = 16
);
    logic                       ctrl_drain_en;
    logic [ROW_CNT_W-1:0]       cfg_rows;
    logic [4:0]                 cfg_shift;
    logic                       acc_valid;
    logic [NUM_COL*ACC_W-1:0]   acc_data;
    logic                       acc_ready;
    logic                       m_tvalid;
    logic [31:0]                m_tdata;
    logic                       m_tlast;
    logic                       m_tready;
    logic                       drain_done;
    logic                       busy;
    modport master (
        input  ctrl_drain_en, cfg_rows, cfg_shift, acc_valid, acc_data, m_tready,
        output acc_ready, m_tvalid, m_tdata, m_tlast, drain_done, busy
    );
    modport slave (
        output ctrl_drain_en, cfg_rows, cfg_shift, acc_valid, acc_data, m_tready,
        input  acc_ready, m_tvalid, m_tdata, m_tlast, drain_done, busy
    );
endinterface

// File: rtl/output_drain_packer.sv
// output_drain_packer: requantizes accumulator rows to int8 and streams them as 32-bit beats.
module output_drain_packer #(
    parameter int NUM_COL   = 8,
    parameter int ACC_W     = 32,
    parameter int ROW_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    output_drain_packer_if.master   bus
);
    localparam int NB = NUM_COL / 4;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-128);
    typedef enum logic [2:0] {S_IDLE, S_WAIT_ROW, S_QUANT, S_SEND, S_DONE} state_t;
    state_t                     r_state, w_next;
    logic [ROW_CNT_W-1:0]       r_rows, r_row;
    logic [4:0]                 r_shift;
    logic [BW-1:0]              r_beat;
    logic [NUM_COL*ACC_W-1:0]   r_data;
    logic [NUM_COL*8-1:0]       r_bytes, w_bytes;
    logic                       w_last_beat, w_last_row, w_beat_fire;
    logic signed [ACC_W:0]      w_rnd;
    assign w_rnd       = (r_shift == 5'd0) ? '0 : (ACC_W+1)'(1) << (r_shift - 5'd1);
    assign w_last_beat = r_beat == BW'(NB - 1);
    assign w_last_row  = r_row == r_rows - ROW_CNT_W'(1);
    assign w_beat_fire = (r_state == S_SEND) && bus.m_tready;
    // One extra bit of headroom so the rounding add can never wrap.
    for (genvar c = 0; c < NUM_COL; c++) begin : g_lane
        logic signed [ACC_W:0] w_sum, w_sh;
        assign w_sum = $signed({r_data[c*ACC_W+ACC_W-1], r_data[c*ACC_W +: ACC_W]}) + w_rnd;
        assign w_sh  = w_sum >>> r_shift;
        assign w_bytes[8*c +: 8] = (w_sh > MAXV) ? 8'h7F : (w_sh < MINV) ? 8'h80 : w_sh[7:0];
    end
    // Every output decodes registered state only, so m_tready never reaches m_tvalid.
    assign bus.acc_ready  = r_state == S_WAIT_ROW;
    assign bus.m_tvalid   = r_state == S_SEND;
    assign bus.m_tdata    = bus.m_tvalid ? r_bytes[32*r_beat +: 32] : '0;
    assign bus.m_tlast    = bus.m_tvalid && w_last_beat && w_last_row;
    assign bus.drain_done = r_state == S_DONE;
    assign bus.busy       = r_state != S_IDLE;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.ctrl_drain_en) w_next = (bus.cfg_rows == '0) ? S_DONE : S_WAIT_ROW;
            S_WAIT_ROW: if (bus.acc_valid) w_next = S_QUANT;
            S_QUANT:    w_next = S_SEND;
            S_SEND:     if (bus.m_tready && w_last_beat) w_next = w_last_row ? S_DONE : S_WAIT_ROW;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rows  <= '0;
            r_row   <= '0;
            r_shift <= '0;
            r_beat  <= '0;
            r_data  <= '0;
            r_bytes <= '0;
        end else begin
            if (r_state == S_IDLE && bus.ctrl_drain_en) begin
                r_rows  <= bus.cfg_rows;
                r_shift <= bus.cfg_shift;
                r_row   <= '0;
                r_beat  <= '0;
            end
            if (bus.acc_ready && bus.acc_valid) r_data <= bus.acc_data;
            if (r_state == S_QUANT) r_bytes <= w_bytes;
            if (w_beat_fire) begin
                r_beat <= w_last_beat ? '0 : r_beat + BW'(1);
                if (w_last_beat && !w_last_row) r_row <= r_row + ROW_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_output_drain_packer.sv
// tb_output_drain_packer: directed scenario tasks with hand-computed beats for output_drain_packer.
module tb_output_drain_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    output_drain_packer_if #(.NUM_COL(8), .ACC_W(32), .ROW_CNT_W(16)) bus_if ();
    output_drain_packer #(.NUM_COL(8), .ACC_W(32), .ROW_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus_if)
    );
    int n_tests = 0;
    int n_fail = 0;
    logic [255:0] row_mem [4];
    logic [31:0]  beat_d [16];
    logic         beat_l [16];
    int nbeat, hs_cnt, done_cnt, done_cyc, last_cyc, stall_err, ar_seen, tv_seen, stalls;
    logic busy_after;
    task automatic set_col(input int r, input int c, input int v);
        row_mem[r][c*32 +: 32] = 32'(v);
    endtask
    // Runs one drain; ctrl_drain_en and cfg are disturbed after the start to show they are ignored.
    task automatic do_run(input int rows, input logic [4:0] sh, input bit stall);
        int stall_left = 0;
        bit prev_st = 0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        nbeat = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
        stall_err = 0; ar_seen = 0; tv_seen = 0; stalls = 0; busy_after = 1'bx;
        @(negedge clk);
        bus_if.cfg_rows = 16'(rows); bus_if.cfg_shift = sh; bus_if.ctrl_drain_en = 1'b1;
        bus_if.acc_valid = rows > 0; bus_if.acc_data = row_mem[0]; bus_if.m_tready = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            bus_if.ctrl_drain_en = 1'b0; bus_if.cfg_rows = '1; bus_if.cfg_shift = 5'd7;
            if (prev_st && (!bus_if.m_tvalid || bus_if.m_tdata !== pd || bus_if.m_tlast !== pl)) stall_err++;
            if (bus_if.m_tvalid && bus_if.acc_ready) stall_err++;
            if (bus_if.acc_ready) ar_seen++;
            if (bus_if.m_tvalid) tv_seen++;
            if (bus_if.drain_done) begin done_cnt++; if (done_cyc < 0) done_cyc = n; end
            if (stall && bus_if.m_tvalid && stall_left == 0 && $urandom_range(0, 1) == 1) begin
                stall_left = $urandom_range(1, 10);
                stalls++;
            end
            bus_if.m_tready = stall_left == 0;
            if (stall_left > 0) stall_left--;
            bus_if.acc_valid = hs_cnt < rows;
            bus_if.acc_data = row_mem[hs_cnt < 4 ? hs_cnt : 0];
            if (bus_if.acc_valid && bus_if.acc_ready) hs_cnt++;
            if (bus_if.m_tvalid && bus_if.m_tready && nbeat < 16) begin
                beat_d[nbeat] = bus_if.m_tdata; beat_l[nbeat] = bus_if.m_tlast;
                nbeat++; last_cyc = n;
            end
            prev_st = bus_if.m_tvalid && !bus_if.m_tready;
            pd = bus_if.m_tdata; pl = bus_if.m_tlast;
            if (done_cyc > 0 && n == done_cyc + 1) begin busy_after = bus_if.busy; break; end
        end
        bus_if.acc_valid = 1'b0; bus_if.m_tready = 1'b1;
        n_tests++;
        if (done_cyc < 0) begin n_fail++; $display("FAIL run_timeout: drain_done never seen within 400 cycles"); end
    endtask
    task automatic test_reset();
        bus_if.ctrl_drain_en = 1'b1; bus_if.acc_valid = 1'b1; bus_if.m_tready = 1'b1;
        bus_if.cfg_rows = 16'd1; bus_if.cfg_shift = '0; bus_if.acc_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests += 6;
        if (bus_if.acc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_acc_ready: got %b want 0", bus_if.acc_ready); end
        if (bus_if.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", bus_if.m_tvalid); end
        if (bus_if.m_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", bus_if.m_tdata); end
        if (bus_if.m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", bus_if.m_tlast); end
        if (bus_if.drain_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus_if.drain_done); end
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        bus_if.ctrl_drain_en = 1'b0; bus_if.acc_valid = 1'b0;
        rst = 1'b0;
    endtask
    task automatic check_two_beats(input string nm, input logic [31:0] e0, input logic [31:0] e1);
        n_tests += 6;
        if (nbeat !== 2) begin n_fail++; $display("FAIL %s_nbeat: got %0d want 2", nm, nbeat); end
        if (beat_d[0] !== e0) begin n_fail++; $display("FAIL %s_beat0: got %h want %h", nm, beat_d[0], e0); end
        if (beat_d[1] !== e1) begin n_fail++; $display("FAIL %s_beat1: got %h want %h", nm, beat_d[1], e1); end
        if (beat_l[0] !== 1'b0 || beat_l[1] !== 1'b1) begin n_fail++; $display("FAIL %s_tlast: got %b%b want 01", nm, beat_l[0], beat_l[1]); end
        if (done_cnt !== 1) begin n_fail++; $display("FAIL %s_done_cnt: got %0d want 1", nm, done_cnt); end
        if (busy_after !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after: got %b want 0", nm, busy_after); end
    endtask
    task automatic test_basic();
        for (int c = 0; c < 8; c++) set_col(0, c, c);
        do_run(1, 5'd0, 1'b0);
        check_two_beats("basic", 32'h03020100, 32'h07060504);
        n_tests += 2;
        if (done_cyc !== last_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing: done at %0d want %0d", done_cyc, last_cyc + 1); end
        if (hs_cnt !== 1) begin n_fail++; $display("FAIL basic_handshakes: got %0d want 1", hs_cnt); end
    endtask
    task automatic test_quant();
        set_col(0, 0, 200); set_col(0, 1, -24); set_col(0, 2, 10000); set_col(0, 3, -100000);
        set_col(0, 4, 8); set_col(0, 5, -8); set_col(0, 6, -1); set_col(0, 7, 0);
        do_run(1, 5'd4, 1'b0);
        check_two_beats("quant", 32'h807FFF0D, 32'h00000001);
    endtask
    task automatic test_saturate();
        set_col(0, 0, 127); set_col(0, 1, 128); set_col(0, 2, -128); set_col(0, 3, -129);
        set_col(0, 4, 32'h7FFFFFFF); set_col(0, 5, 32'h80000000); set_col(0, 6, 5); set_col(0, 7, -5);
        do_run(1, 5'd0, 1'b0);
        check_two_beats("saturate", 32'h80807F7F, 32'hFB05807F);
    endtask
    task automatic test_shift_max();
        set_col(0, 0, 32'h7FFFFFFF); set_col(0, 1, 32'h80000000); set_col(0, 2, 32'h40000000); set_col(0, 3, 32'hC0000000);
        set_col(0, 4, 0); set_col(0, 5, 1); set_col(0, 6, -1); set_col(0, 7, 32'h3FFFFFFF);
        do_run(1, 5'd31, 1'b0);
        check_two_beats("shift31", 32'h0001FF01, 32'h00000000);
    endtask
    task automatic test_stall();
        logic [31:0] e;
        for (int r = 0; r < 2; r++) for (int c = 0; c < 8; c++) set_col(r, c, 2 * (16 * r + c) + 1);
        do_run(2, 5'd1, 1'b1);
        n_tests += 4;
        if (nbeat !== 4) begin n_fail++; $display("FAIL stall_nbeat: got %0d want 4", nbeat); end
        if (stall_err !== 0) begin n_fail++; $display("FAIL stall_stability: got %0d violations want 0", stall_err); end
        if (stalls < 1) begin n_fail++; $display("FAIL stall_exercised: got %0d stalls want >=1", stalls); end
        if (done_cnt !== 1) begin n_fail++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
        for (int k = 0; k < 4 && k < nbeat; k++) begin
            for (int j = 0; j < 4; j++) e[8*j +: 8] = 8'(16 * (k / 2) + 4 * (k % 2) + j + 1);
            n_tests++;
            if (beat_d[k] !== e || beat_l[k] !== (k == 3)) begin
                n_fail++; $display("FAIL stall_beat%0d: got %h/%b want %h/%b", k, beat_d[k], beat_l[k], e, k == 3);
            end
        end
    endtask
    task automatic test_back_to_back();
        logic [31:0] e;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 8; c++) set_col(r, c, 'h40 + 16 * r + c);
        do_run(3, 5'd0, 1'b0);
        n_tests += 4;
        if (nbeat !== 6) begin n_fail++; $display("FAIL b2b_nbeat: got %0d want 6", nbeat); end
        if (hs_cnt !== 3) begin n_fail++; $display("FAIL b2b_handshakes: got %0d want 3", hs_cnt); end
        if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); end
        if (stall_err !== 0) begin n_fail++; $display("FAIL b2b_overlap: got %0d violations want 0", stall_err); end
        for (int k = 0; k < 6 && k < nbeat; k++) begin
            for (int j = 0; j < 4; j++) e[8*j +: 8] = 8'('h40 + 16 * (k / 2) + 4 * (k % 2) + j);
            n_tests++;
            if (beat_d[k] !== e || beat_l[k] !== (k == 5)) begin
                n_fail++; $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", k, beat_d[k], beat_l[k], e, k == 5);
            end
        end
    endtask
    task automatic test_zero_rows();
        do_run(0, 5'd0, 1'b0);
        n_tests += 4;
        if (done_cyc < 1 || done_cyc > 2) begin n_fail++; $display("FAIL zero_done_timing: got %0d want 1..2", done_cyc); end
        if (ar_seen !== 0) begin n_fail++; $display("FAIL zero_acc_ready: got %0d cycles want 0", ar_seen); end
        if (tv_seen !== 0) begin n_fail++; $display("FAIL zero_tvalid: got %0d cycles want 0", tv_seen); end
        if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    endtask
    task automatic test_reset_mid();
        bit seen = 0;
        for (int c = 0; c < 8; c++) set_col(0, c, c);
        @(negedge clk);
        bus_if.cfg_rows = 16'd1; bus_if.cfg_shift = '0; bus_if.ctrl_drain_en = 1'b1;
        bus_if.acc_valid = 1'b1; bus_if.acc_data = row_mem[0]; bus_if.m_tready = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            bus_if.ctrl_drain_en = 1'b0;
            seen = bus_if.m_tvalid;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rstmid_reach_send: tvalid never seen within 20 cycles"); end
        bus_if.acc_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus_if.acc_ready, bus_if.m_tvalid, bus_if.m_tdata, bus_if.m_tlast, bus_if.drain_done, bus_if.busy} !== 37'h0) begin
            n_fail++; $display("FAIL rstmid_outputs: got tvalid=%b tdata=%h tlast=%b busy=%b want all 0",
                               bus_if.m_tvalid, bus_if.m_tdata, bus_if.m_tlast, bus_if.busy);
        end
        rst = 1'b0;
        bus_if.m_tready = 1'b1;
        do_run(1, 5'd0, 1'b0);
        check_two_beats("rstmid_rerun", 32'h03020100, 32'h07060504);
    endtask
    initial begin
        bus_if.ctrl_drain_en = 1'b0; bus_if.cfg_rows = '0; bus_if.cfg_shift = '0;
        bus_if.acc_valid = 1'b0; bus_if.acc_data = '0; bus_if.m_tready = 1'b0;
        for (int r = 0; r < 4; r++) row_mem[r] = '0;
        test_reset();
        test_basic();
        test_quant();
        test_saturate();
        test_shift_max();
        test_stall();
        test_back_to_back();
        test_zero_rows();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
